// File: rtl/mod_counter_pkg.sv
// Shared helpers for the modulo up/down counter.
//   clog2_min1 : ceil(log2(n)), never less than 1 (sizes the prescaler)
//   DIR_UP/DIR_DOWN : encodings of the 'up' direction input
package mod_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mod_updown_counter_prescale_tick.sv
// Clock-enable prescaler: emits one tick every PRESCALE enabled cycles.
//   clk      : rising-edge clock
//   rst      : asynchronous active-low reset
//   en       : advances the prescaler
//   sync_clr : synchronous return to phase 0 (counter clear/load)
//   tick     : combinational, en && prescaler at its last phase
module prescale_tick
  import mod_counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic sync_clr,
  output logic tick
);

  localparam int             PW   = clog2_min1(PRESCALE);
  localparam logic [PW-1:0]  LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] r_pre;

  // With PRESCALE = 1, LAST is 0 and r_pre never leaves 0, so tick == en.
  assign tick = en && (r_pre == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          r_pre <= '0;
    else if (sync_clr) r_pre <= '0;
    else if (en)       r_pre <= tick ? '0 : r_pre + PW'(1);
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Parametrised modulo up/down counter with prescaler, load/clear,
// optional saturation and registered boundary flags.
//   clk, rst        : clock, asynchronous active-low reset
//   en              : count enable (also advances the prescaler)
//   up              : 1 = increment, 0 = decrement
//   load, load_val  : synchronous load, clamped to MAX_VAL
//   clr             : synchronous clear (highest priority)
//   count           : registered count
//   wrap            : registered one-cycle pulse alongside the wrapped value
//   tc              : combinational, next step crosses a boundary
//   at_max, at_zero : registered boundary flags aligned with count
module mod_updown_counter
  import mod_counter_pkg::*;
#(
  parameter int          WIDTH    = 4,
  parameter int unsigned MAX_VAL  = 32'((64'd1 << WIDTH) - 64'd1),
  parameter int          PRESCALE = 1,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             tc,
  output logic             at_max,
  output logic             at_zero
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_at_max;
  logic             r_at_zero;

  logic             w_tick;
  logic             w_sync_clr;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic             w_wrap_nxt;
  logic             w_at_top;
  logic             w_at_bot;

  // clr and load both restart the prescaler phase.
  assign w_sync_clr = clr | load;

  prescale_tick #(
    .PRESCALE (PRESCALE)
  ) u_pre (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .sync_clr (w_sync_clr),
    .tick     (w_tick)
  );

  assign w_at_top = (r_count == MAXV);
  assign w_at_bot = (r_count == '0);

  // Boundary test ignores clr/load on purpose: tc only flags the step itself.
  assign tc = w_tick && ((up == DIR_UP) ? w_at_top : w_at_bot);

  always_comb begin
    w_cnt_nxt  = r_count;
    w_wrap_nxt = 1'b0;
    if (clr) begin
      w_cnt_nxt = '0;
    end else if (load) begin
      w_cnt_nxt = (load_val > MAXV) ? MAXV : load_val;
    end else if (w_tick) begin
      if (up == DIR_UP) begin
        if (!w_at_top) begin
          w_cnt_nxt = r_count + WIDTH'(1);
        end else if (!SATURATE) begin
          w_cnt_nxt  = '0;
          w_wrap_nxt = 1'b1;
        end
      end else begin
        if (!w_at_bot) begin
          w_cnt_nxt = r_count - WIDTH'(1);
        end else if (!SATURATE) begin
          w_cnt_nxt  = MAXV;
          w_wrap_nxt = 1'b1;
        end
      end
    end
  end

  // Flags derive from the next-state value so they line up with count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count   <= '0;
      r_wrap    <= 1'b0;
      r_at_max  <= 1'b0;
      r_at_zero <= 1'b1;
    end else begin
      r_count   <= w_cnt_nxt;
      r_wrap    <= w_wrap_nxt;
      r_at_max  <= (w_cnt_nxt == MAXV);
      r_at_zero <= (w_cnt_nxt == '0);
    end
  end

  assign count   = r_count;
  assign wrap    = r_wrap;
  assign at_max  = r_at_max;
  assign at_zero = r_at_zero;

endmodule

// File: doc/mod_updown_counter.md
Name: mod_updown_counter

Overview:
Parametrised modulo up/down counter, the next generation of the team's 4-bit free-running up-counter. It adds:
- configurable width and modulus
- direction control, synchronous load and clear
- a clock-enable prescaler
- optional saturation instead of wrap
- registered wrap and boundary status flags

It serves as a general timing/event counter inside datapath and control blocks.

Parameters:
WIDTH, 4, bit width of count (1..32)
MAX_VAL, 2**WIDTH-1, highest count value; range 0..MAX_VAL; must be less than or equal to 2**WIDTH-1
PRESCALE, 1, number of enabled cycles per count step (1 = every enabled cycle)
SATURATE, 0, 0 = wrap at boundaries, 1 = hold at boundaries

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset (0 = reset)
en  input  1  count enable; also advances the prescaler
up  input  1  direction: 1 = increment, 0 = decrement
load  input  1  synchronous load of load_val
load_val  input  WIDTH  value to load
clr  input  1  synchronous clear to 0
count  output  WIDTH  current count, registered
wrap  output  1  one-cycle registered pulse, asserted in the same cycle count shows the wrapped value
tc  output  1  combinational terminal-count; high when the next step crosses a boundary (en && step_tick && boundary for current direction)
at_max  output  1  registered; count == MAX_VAL
at_zero  output  1  registered; count == 0

Behaviour:
- Reset (rst low, asynchronous, any time including mid-step):
  - count = 0, prescaler = 0, wrap = 0, at_max = 0, at_zero = 1.
  - Deassertion is sampled at the next rising clk.
- Priority per cycle: clr > load > step > hold.
- clr: count <= 0, prescaler <= 0, wrap <= 0. Takes effect even when en = 0.
- load: count <= min(load_val, MAX_VAL), prescaler <= 0, wrap <= 0. Takes effect even when en = 0.
- Prescaler:
  - Internal counter of width clog2(PRESCALE), minimum 1 bit.
  - Increments only when en = 1.
  - step_tick = en && (prescaler == PRESCALE-1); the prescaler returns to 0 on step_tick.
  - PRESCALE = 1 gives step_tick = en.
- Step (on step_tick):
  - up = 1:
    - count < MAX_VAL: count + 1.
    - count == MAX_VAL, SATURATE = 0: count <= 0 and wrap <= 1.
    - count == MAX_VAL, SATURATE = 1: count holds and wrap <= 0.
  - up = 0:
    - count > 0: count - 1.
    - count == 0, SATURATE = 0: count <= MAX_VAL and wrap <= 1.
    - count == 0, SATURATE = 1: count holds and wrap <= 0.
- wrap is 0 on every cycle without a wrapping step.
- Latency:
  - count, at_max, at_zero update one cycle after the qualifying edge.
  - tc is combinational and valid in the cycle before the wrap.
- Direction changes take effect on the next step; the prescaler is not affected.
- Arithmetic is done in WIDTH bits. Never produce a value above MAX_VAL.
- With MAX_VAL < 2**WIDTH-1, values above MAX_VAL are unreachable, since load clamps.
- at_max and at_zero are computed from the next-state value and registered, so they align with count.

Decomposition:
- Package mod_counter_pkg:
  - function clog2_min1(n)
  - localparam constants DIR_UP = 1'b1, DIR_DOWN = 1'b0
- Sub-module prescale_tick: owns the prescaler register.
  - Inputs: clk, rst, en, sync_clr.
  - Output: tick.
  - Parameter: PRESCALE.
- The top level holds the count register, the boundary logic and the flags.

Test Plan:
1. Reset and wrap: WIDTH = 4, defaults. Hold rst = 0 for 2 cycles, then en = 1, up = 1 for 17 cycles. Required: count 0..15 then 0; wrap high exactly in the cycle count = 0 after 15; tc high while count = 15.
2. Down with odd modulus: MAX_VAL = 9, up = 0, en = 1 from count = 0. Required: 9, 8, ..., 0, 9; wrap pulse on each 0 -> 9; at_zero high only when count = 0.
3. Prescaler: PRESCALE = 3, en = 1 continuously. Required: count increments on every 3rd cycle. Drop en for 2 cycles mid-period: the step is delayed by exactly 2 cycles.
4. Load and clear priority: in the same cycle drive clr = 1, load = 1, load_val = 7. Required: count = 0. Next cycle load = 1, load_val = 12 with MAX_VAL = 9. Required: count = 9, at_max = 1.
5. Saturation: SATURATE = 1, MAX_VAL = 5, count up for 10 steps, then down for 10 steps. Required: holds at 5, then holds at 0; wrap never asserts.
6. Asynchronous reset mid-count: count = 6, assert rst low between clock edges. Required: count = 0 and at_zero = 1 immediately, without waiting for a clock edge. After release, counting resumes from 1 on the first enabled step (PRESCALE = 1).
